iter_div: RTL and testbench
===========================

Name: iter_div

Overview:
- Parametrised, self-contained multi-cycle integer divider for the EX stage. Replaces the vendor divider IP and its per-operand valid/ready bookkeeping.
- Handles signed and unsigned division through one datapath, selected per operation. Produces quotient and remainder together.
- Uses a single input handshake and a single output handshake, with a pipeline flush input driven by WB (exception, ertn, refetch).
- Radix-2 restoring algorithm: one quotient bit per clock.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits; legal range 4..64.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of any operation in flight (WB ex / ertn / refetch).
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  divider can accept a new operation this cycle.
- signed_op  input  1  1 = signed (div/mod), 0 = unsigned (divu/modu).
- dividend  input  WIDTH  rj operand.
- divisor  input  WIDTH  rk operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result this cycle.
- quotient  output  WIDTH  quotient result.
- remainder  output  WIDTH  remainder result.
- div_by_zero  output  1  divisor was zero; qualified by out_valid.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; iteration counter=0.
- States:
  - IDLE: in_ready=1.
  - CALC: in_ready=0, out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept: occurs on a clock edge where in_valid && in_ready && !flush. The accept latches:
  - |dividend| and |divisor| (two's-complement negate when signed_op and MSB=1; unsigned operands taken as-is);
  - quotient sign = dividend MSB XOR divisor MSB (signed only);
  - remainder sign = dividend MSB (signed only).
- IDLE to CALC: on accept with divisor != 0. Counter loads WIDTH-1.
- IDLE to DONE: on accept with divisor == 0. Results forced to quotient = all ones, remainder = dividend (raw input, unmodified), div_by_zero=1. Latency is 1 edge.
- CALC step, each edge:
  - partial remainder (WIDTH+1 bits) shifts left by one, taking the next dividend bit;
  - trial subtract of |divisor|; if the result is non-negative, keep it and set the quotient bit to 1, otherwise restore and set it to 0;
  - counter decrements.
- CALC to DONE: on the edge where the step runs with counter==0. Sign fix-up (conditional negation of quotient and remainder) is applied in that same edge, so DONE outputs are final and registered.
- Latency: out_valid rises exactly WIDTH edges after the accept edge (32 for WIDTH=32). Latency does not depend on the data.
- DONE behaviour:
  - quotient, remainder and div_by_zero stay stable while out_ready=0.
  - out_ready=1 with in_valid=0: go to IDLE.
  - out_ready=1 with in_valid=1: back-to-back accept on the same edge, going to CALC, or to DONE when the divisor is 0. out_valid stays high only in the divisor==0 case, and then carries the new result.
- Signed overflow: MIN / -1 gives quotient = MIN, remainder = 0, div_by_zero=0. This is the natural result of the unsigned core plus fix-up; no special path.
- Remainder sign always follows the dividend, and |remainder| < |divisor| (truncating division, LoongArch semantics).
- flush:
  - Highest priority among synchronous events. From any state, the next state is IDLE and out_valid=0 on the next edge.
  - in_valid in the flush cycle is ignored.
  - A result in DONE is discarded, even if out_ready=1 in that cycle.
- resetn asserted mid-CALC: immediate return to the reset values. No partial result is ever presented.
- The quotient and remainder registers are not cleared on flush. They are don't-care whenever out_valid=0.

Test Plan:
- WIDTH=32, unsigned, 100 / 7 -> quotient=14, remainder=2, div_by_zero=0. out_valid rises exactly 32 edges after accept. in_ready=0 throughout CALC.
- Signed: -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. 7 / -2 -> quotient=0xFFFFFFFD, remainder=1. 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Divide by zero: dividend=0x12345678, divisor=0, signed and unsigned -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. out_valid 1 edge after accept.
- flush on the 10th CALC cycle -> out_valid never rises; in_ready=1 the next cycle. A following 0xFFFFFFFF / 0x10 (unsigned) gives quotient=0x0FFFFFFF, remainder=0xF. Repeat with resetn pulsed low mid-CALC -> all outputs at reset values immediately.
- Backpressure and back-to-back:
  - hold out_ready=0 for 5 cycles in DONE -> outputs unchanged;
  - then out_ready=1 with in_valid=1 (50 / 5, unsigned) -> accepted on the same edge; next result quotient=10, remainder=0 after 32 edges;
  - flush together with out_ready=1 in DONE -> result dropped, state IDLE.
- WIDTH=8 build, 1000 random signed/unsigned pairs checked against a reference model. Includes 0x80 / 0xFF -> quotient=0x80, remainder=0. Latency is 8 edges.

Source files
------------

// File: rtl/iter_div.sv
// Multi-cycle radix-2 restoring integer divider, signed or unsigned per operation.
// One quotient bit per clock; sign fix-up applied on the final step so results leave registered.
module iter_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prem_q, prem_d;     // partial remainder
    logic [WIDTH-1:0] qacc_q, qacc_d;     // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;       // |divisor|
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   prem_sh;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] qacc_next;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;

    // One restoring step: shift in next dividend bit, trial-subtract |divisor|.
    assign prem_sh   = {prem_q, qacc_q[WIDTH-1]};
    assign trial     = prem_sh - {1'b0, dvs_q};
    assign qbit      = ~trial[WIDTH];
    assign prem_next = qbit ? trial[WIDTH-1:0] : prem_sh[WIDTH-1:0];
    assign qacc_next = {qacc_q[WIDTH-2:0], qbit};

    assign dvd_abs = (signed_op && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_abs = (signed_op && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        qacc_d    = qacc_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_CALC: begin
                cnt_d  = cnt_q - CW'(1);
                prem_d = prem_next;
                qacc_d = qacc_next;
                quo_d  = qneg_q ? (~qacc_next + WIDTH'(1)) : qacc_next;
                rem_d  = rneg_q ? (~prem_next + WIDTH'(1)) : prem_next;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept; a zero divisor bypasses the iteration entirely.
        if (in_valid && in_ready && !flush) begin
            prem_d = '0;
            qacc_d = dvd_abs;
            dvs_d  = dvs_abs;
            qneg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d = signed_op & dividend[WIDTH-1];
            cnt_d  = CW'(WIDTH - 1);
            if (divisor == '0) begin
                state_d = S_DONE;
                quo_d   = '1;
                rem_d   = dividend;
                dbz_d   = 1'b1;
            end else begin
                state_d = S_CALC;
                dbz_d   = 1'b0;
            end
        end

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            qacc_q  <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            qacc_q  <= qacc_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_div.sv
// Directed and model-checked bench for iter_div at WIDTH=32 and WIDTH=8.
module tb_iter_div;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        a_flush = 1'b0, a_in_valid = 1'b0, a_signed = 1'b0, a_out_ready = 1'b0;
    logic [31:0] a_dividend = '0, a_divisor = '0;
    logic        a_in_ready, a_out_valid, a_dbz;
    logic [31:0] a_quotient, a_remainder;

    logic        b_flush = 1'b0, b_in_valid = 1'b0, b_signed = 1'b0, b_out_ready = 1'b0;
    logic [7:0]  b_dividend = '0, b_divisor = '0;
    logic        b_in_ready, b_out_valid, b_dbz;
    logic [7:0]  b_quotient, b_remainder;

    int checks = 0;
    int errors = 0;

    iter_div #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .signed_op(a_signed),
        .dividend(a_dividend), .divisor(a_divisor),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .quotient(a_quotient), .remainder(a_remainder), .div_by_zero(a_dbz)
    );

    iter_div #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .signed_op(b_signed),
        .dividend(b_dividend), .divisor(b_divisor),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .quotient(b_quotient), .remainder(b_remainder), .div_by_zero(b_dbz)
    );

    // n = edges after the accept edge until out_valid is seen (0 means the accept edge itself).
    task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] d,
                           output int n, output int rdy_seen);
        a_signed = s; a_dividend = a; a_divisor = d; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n = 0; rdy_seen = 0;
        while (!a_out_valid && n < 100) begin
            if (a_in_ready) rdy_seen++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] d, output int n);
        b_signed = s; b_dividend = a; b_divisor = d; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic consume32();
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic consume8();
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
    endtask

    function automatic void ref8(input logic s, input logic [7:0] a, input logic [7:0] d,
                                 output logic [7:0] q, output logic [7:0] r);
        int sa, sb;
        if (d == 8'h00) begin
            q = 8'hFF; r = a;
        end else if (s) begin
            sa = $signed(a); sb = $signed(d);
            q = 8'(sa / sb); r = 8'(sa % sb);
        end else begin
            q = a / d; r = a % d;
        end
    endfunction

    task automatic test_reset();
        checks++;
        if ({a_in_ready, a_out_valid, a_dbz, a_quotient, a_remainder} !== {3'b100, 64'h0}) begin
            errors++;
            $display("FAIL reset32: rdy=%b vld=%b dbz=%b q=%h r=%h, want 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_dbz, a_quotient, a_remainder);
        end
        checks++;
        if ({b_in_ready, b_out_valid, b_dbz, b_quotient, b_remainder} !== {3'b100, 16'h0}) begin
            errors++;
            $display("FAIL reset8: rdy=%b vld=%b dbz=%b q=%h r=%h, want 1 0 0 0 0",
                     b_in_ready, b_out_valid, b_dbz, b_quotient, b_remainder);
        end
    endtask

    task automatic test_unsigned();
        int n, rs;
        issue32(1'b0, 32'd100, 32'd7, n, rs);
        checks++;
        if (a_quotient !== 32'd14 || a_remainder !== 32'd2 || a_dbz !== 1'b0) begin
            errors++;
            $display("FAIL udiv_100_7: q=%0d r=%0d dbz=%b, want 14 2 0", a_quotient, a_remainder, a_dbz);
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL udiv_latency: got %0d edges, want 32", n);
        end
        checks++;
        if (rs !== 0) begin
            errors++;
            $display("FAIL calc_in_ready: in_ready high in %0d CALC cycles, want 0", rs);
        end
        consume32();
    endtask

    task automatic test_signed();
        logic [31:0] va [3] = '{32'hFFFFFFF9, 32'd7,        32'h80000000};
        logic [31:0] vd [3] = '{32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] eq [3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000};
        logic [31:0] er [3] = '{32'hFFFFFFFF, 32'd1,        32'd0};
        int n, rs;
        for (int i = 0; i < 3; i++) begin
            issue32(1'b1, va[i], vd[i], n, rs);
            checks++;
            if (a_quotient !== eq[i] || a_remainder !== er[i] || a_dbz !== 1'b0 || n !== 32) begin
                errors++;
                $display("FAIL sdiv[%0d]: q=%h r=%h dbz=%b lat=%0d, want %h %h 0 32",
                         i, a_quotient, a_remainder, a_dbz, n, eq[i], er[i]);
            end
            consume32();
        end
    endtask

    task automatic test_div_zero();
        int n, rs;
        for (int s = 0; s < 2; s++) begin
            issue32(1'(s), 32'h12345678, 32'h0, n, rs);
            checks++;
            if (a_quotient !== 32'hFFFFFFFF || a_remainder !== 32'h12345678 || a_dbz !== 1'b1 || n !== 0) begin
                errors++;
                $display("FAIL divzero[s=%0d]: q=%h r=%h dbz=%b lat=%0d, want ffffffff 12345678 1 0",
                         s, a_quotient, a_remainder, a_dbz, n);
            end
            consume32();
        end
    endtask

    task automatic test_flush();
        int n, rs, seen;
        a_signed = 1'b0; a_dividend = 32'd1000; a_divisor = 32'd3; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        a_flush = 1'b1; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_calc: vld=%b rdy=%b, want 0 1", a_out_valid, a_in_ready);
        end
        seen = 0;
        repeat (40) begin
            if (a_out_valid) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_result: out_valid seen %0d cycles, want 0", seen);
        end
        issue32(1'b0, 32'hFFFFFFFF, 32'h10, n, rs);
        checks++;
        if (a_quotient !== 32'h0FFFFFFF || a_remainder !== 32'hF || n !== 32) begin
            errors++;
            $display("FAIL after_flush: q=%h r=%h lat=%0d, want 0fffffff f 32", a_quotient, a_remainder, n);
        end
        consume32();

        // Asynchronous reset in the middle of an iteration.
        a_signed = 1'b0; a_dividend = 32'd12345; a_divisor = 32'd17; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({a_in_ready, a_out_valid, a_dbz, a_quotient, a_remainder} !== {3'b100, 64'h0}) begin
            errors++;
            $display("FAIL reset_mid_calc: rdy=%b vld=%b dbz=%b q=%h r=%h, want 1 0 0 0 0",
                     a_in_ready, a_out_valid, a_dbz, a_quotient, a_remainder);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n, rs, bad;
        issue32(1'b0, 32'd1000, 32'd3, n, rs);
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (a_out_valid !== 1'b1 || a_quotient !== 32'd333 || a_remainder !== 32'd1 || a_dbz !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d unstable cycles, q=%0d r=%0d, want 333 1", bad, a_quotient, a_remainder);
        end
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_ready_low: in_ready=%b with out_ready=0, want 0", a_in_ready);
        end

        // Consume and accept 50/5 on the same edge.
        a_signed = 1'b0; a_dividend = 32'd50; a_divisor = 32'd5;
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_ready_follow: in_ready=%b with out_ready=1, want 1", a_in_ready);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        n = 0;
        while (!a_out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (a_quotient !== 32'd10 || a_remainder !== 32'd0 || n !== 32) begin
            errors++;
            $display("FAIL b2b_50_5: q=%0d r=%0d lat=%0d, want 10 0 32", a_quotient, a_remainder, n);
        end

        // Back-to-back into a zero divisor keeps out_valid high with the new result.
        a_signed = 1'b1; a_dividend = 32'hDEADBEEF; a_divisor = 32'h0;
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_quotient !== 32'hFFFFFFFF || a_remainder !== 32'hDEADBEEF || a_dbz !== 1'b1) begin
            errors++;
            $display("FAIL b2b_divzero: vld=%b q=%h r=%h dbz=%b, want 1 ffffffff deadbeef 1",
                     a_out_valid, a_quotient, a_remainder, a_dbz);
        end

        // Flush with out_ready in DONE drops the result; in_valid is ignored too.
        a_flush = 1'b1; a_out_ready = 1'b1; a_in_valid = 1'b1; a_divisor = 32'h0;
        @(posedge clk); #1;
        a_flush = 1'b0; a_out_ready = 1'b0; a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: vld=%b rdy=%b, want 0 1", a_out_valid, a_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_idle: vld=%b one cycle later, want 0", a_out_valid);
        end
    endtask

    task automatic test_random8();
        logic [7:0] a, d, eq, er;
        logic       s;
        int         n;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); d = 8'($urandom); s = 1'($urandom);
            if (i == 0) begin a = 8'h80; d = 8'hFF; s = 1'b1; end
            if (i % 50 == 7) d = 8'h00;
            ref8(s, a, d, eq, er);
            issue8(s, a, d, n);
            checks++;
            if (b_quotient !== eq || b_remainder !== er) begin
                errors++;
                $display("FAIL rand8[%0d] s=%b %h/%h: q=%h r=%h, want %h %h", i, s, a, d, b_quotient, b_remainder, eq, er);
            end
            checks++;
            if (b_dbz !== (d == 8'h00) || n !== ((d == 8'h00) ? 0 : 8)) begin
                errors++;
                $display("FAIL rand8_flags[%0d]: dbz=%b lat=%0d, want %b %0d", i, b_dbz, n, (d == 8'h00), (d == 8'h00) ? 0 : 8);
            end
            consume8();
        end
    endtask

    initial begin
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        test_unsigned();
        test_signed();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_random8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
